// File: rtl/sobel_pkg.sv
// Purpose: shared widths, saturation limit and result-entry type for the Sobel sum collector.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package sobel_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 16;
  localparam int MAG_W = 17;
  localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

  // One output FIFO entry: end-of-row flag above the pixel value.
  typedef struct packed {
    logic             last;
    logic [PIX_W-1:0] data;
  } res_t;

  // |a|+|b| widened to MAG_W so that |-32768| and the 65536 worst case stay exact.
  function automatic logic [MAG_W-1:0] abs_sum(input logic signed [SUM_W-1:0] a,
                                               input logic signed [SUM_W-1:0] b);
    logic signed [MAG_W-1:0] ea;
    logic signed [MAG_W-1:0] eb;
    ea = MAG_W'(a);
    eb = MAG_W'(b);
    if (ea < 0) ea = -ea;
    if (eb < 0) eb = -eb;
    return ea + eb;
  endfunction

endpackage

// File: rtl/sobel_sum_collector_if.sv
// Purpose: valid/ready result stream leaving the Sobel sum collector.
// Latency: n/a (wires only).
// Backpressure: m_ready low holds m_data/m_last while m_valid is high.
// Ports: m_valid, m_data[7:0], m_last from the master; m_ready from the slave.
interface sobel_sum_collector_if;
  import sobel_pkg::*;

  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/sobel_out_fifo.sv
// Purpose: synchronous show-ahead FIFO with registered occupancy count.
// Latency: write visible on rd_dat/empty the cycle after it is accepted.
// Backpressure: writes are refused when full unless a read happens in the same cycle.
// Ports: clk, rst, wr_en/wr_dat, rd_en, rd_dat (head entry), empty, full, count.
module sobel_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_rd  = rd_en && !empty;
  // A read in the same cycle frees the head slot, so a full FIFO can still take a write.
  assign do_wr  = wr_en && (!full || do_rd);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd) rd_ptr <= ptr_next(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/sobel_sum_collector.sv
// Purpose: sink of the Gx/Gy PE chains; keeps complete-window sums, outputs saturated |Gx|+|Gy|.
// Latency: pixel broadcast at t -> m_valid at t+LATENCY+2 (empty FIFO, m_ready high).
// Backpressure: PEs cannot stall, so stall_out halts the broadcaster early enough for in-flight sums.
// Ports: clk, rst, pix_valid_in, row_start, gx_in, gy_in, threshold, stall_out, overflow_err, m_if (master stream).
module sobel_sum_collector
  import sobel_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int IMG_WIDTH  = 640,
  parameter int TAPS       = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int THRESH_EN  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid_in,
  input  logic                    row_start,
  input  logic signed [SUM_W-1:0] gx_in,
  input  logic signed [SUM_W-1:0] gy_in,
  input  logic        [PIX_W-1:0] threshold,
  output logic                    stall_out,
  output logic                    overflow_err,
  sobel_sum_collector_if.master   m_if
);

  localparam int WARM_W = $clog2(TAPS + 1);
  localparam int COL_W  = $clog2(IMG_WIDTH + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < LATENCY + 2) begin : g_depth_chk
    $error("sobel_sum_collector: FIFO_DEPTH must be >= LATENCY+2");
  end
  if (IMG_WIDTH < TAPS) begin : g_width_chk
    $error("sobel_sum_collector: IMG_WIDTH must be >= TAPS");
  end

  // Tag delay line: each stage pair {valid, row_start} mirrors one PE-chain stage.
  logic [LATENCY-1:0] tv_q;
  logic [LATENCY-1:0] trs_q;
  logic               tag_vld;
  logic               tag_rs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q  <= '0;
      trs_q <= '0;
    end else begin
      tv_q[0]  <= pix_valid_in;
      trs_q[0] <= pix_valid_in && row_start;
      for (int i = 1; i < LATENCY; i++) begin
        tv_q[i]  <= tv_q[i-1];
        trs_q[i] <= trs_q[i-1];
      end
    end
  end

  assign tag_vld = tv_q[LATENCY-1];
  assign tag_rs  = trs_q[LATENCY-1];

  // Warm-up and column tracking. A row_start tag behaves as if both counters were zero.
  logic [WARM_W-1:0] warm_q;
  logic [WARM_W-1:0] warm_eff;
  logic [COL_W-1:0]  col_q;
  logic [COL_W-1:0]  col_base;
  logic              good;
  logic              good_last;

  assign warm_eff  = tag_rs ? '0 : warm_q;
  assign col_base  = tag_rs ? '0 : col_q;
  assign good      = tag_vld && (warm_eff == WARM_W'(TAPS - 1));
  assign good_last = good && (col_base == COL_W'(IMG_WIDTH - TAPS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_q <= '0;
      col_q  <= '0;
    end else begin
      if (!tag_vld)                         warm_q <= '0;
      else if (tag_rs)                      warm_q <= WARM_W'(1);
      else if (warm_q != WARM_W'(TAPS - 1)) warm_q <= warm_q + WARM_W'(1);

      // Re-sent pixels after a stall are not good, so the column count simply resumes.
      if (good)                col_q <= col_base + COL_W'(1);
      else if (tag_vld && tag_rs) col_q <= '0;
    end
  end

  // Magnitude stage, registered once before the FIFO.
  logic [MAG_W-1:0] mag;
  logic [PIX_W-1:0] sat;
  logic [PIX_W-1:0] res_dat;
  logic             res_vld_q;
  res_t             res_q;

  always_comb begin
    mag = abs_sum(gx_in, gy_in);
    sat = (mag > MAG_W'(PIX_MAX)) ? PIX_MAX : mag[PIX_W-1:0];
    if (THRESH_EN != 0) res_dat = (sat >= threshold) ? PIX_MAX : '0;
    else                res_dat = sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      res_vld_q <= good;
      if (good) begin
        res_q.last <= good_last;
        res_q.data <= res_dat;
      end
    end
  end

  // Output buffer and stream.
  res_t             head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_cnt;
  logic             rd_en;

  assign rd_en = m_if.m_valid && m_if.m_ready;

  sobel_out_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (res_vld_q),
    .wr_dat (res_q),
    .rd_en  (rd_en),
    .rd_dat (head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_cnt)
  );

  // Head is masked while empty so that the stream idles at zero.
  assign m_if.m_valid = !fifo_empty;
  assign m_if.m_data  = fifo_empty ? '0 : head.data;
  assign m_if.m_last  = fifo_empty ? 1'b0 : head.last;

  // Headroom for LATENCY tags still in the chains plus the magnitude register.
  assign stall_out = (fifo_cnt >= CNT_W'(FIFO_DEPTH - LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 overflow_err <= 1'b0;
    else if (res_vld_q && fifo_full && !rd_en) overflow_err <= 1'b1;
  end

endmodule
